// File: rtl/sys_bus_pkg.sv
// sys_bus_pkg: shared types and defaults for the PS register bus initiator
package sys_bus_pkg;

    localparam int AW_DEF      = 16;
    localparam int DW_DEF      = 32;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;

    // Default-width views of a bus command and its response
    typedef struct packed {
        logic              write;
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic [DW_DEF-1:0] rdata;
        logic              err;
    } rsp_t;

    // Width needed to hold a count up to and including timeout
    function automatic int ctr_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// bus_timeout_ctr: counts WAIT cycles and flags the last one before a timeout
module bus_timeout_ctr
    import sys_bus_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = ctr_w(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 2);

    logic [CW-1:0] cnt_q;

    // Cleared during the strobe, advances once per wait cycle
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) cnt_q <= '0;
        else if (en_i)      cnt_q <= cnt_q + 1'b1;
    end

    // The count would reach TIMEOUT-1 on this edge: final cycle to see an ack
    assign expired_o = cnt_q == LAST;

endmodule

// File: rtl/sys_bus_initiator.sv
// sys_bus_initiator: one-at-a-time register bus master with ack timeout
module sys_bus_initiator
    import sys_bus_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_write_i,
    input  logic [AW-1:0] cmd_addr_i,
    input  logic [DW-1:0] cmd_wdata_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [DW-1:0] rsp_rdata_o,
    output logic          rsp_err_o,
    output logic [AW-1:0] addr_o,
    output logic          wen_o,
    output logic          ren_o,
    output logic [DW-1:0] wdata_o,
    input  logic          ack_i,
    input  logic [DW-1:0] rdata_i
);

    typedef struct packed {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_w_t;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_w_t;

    state_t state_q, state_d;
    cmd_w_t cmd_q, cmd_d;
    rsp_w_t rsp_q, rsp_d;
    logic   ready_q, ready_d;
    logic   rsp_valid_q, rsp_valid_d;
    logic   wen_q, wen_d, ren_q, ren_d;
    logic   ctr_expired;

    bus_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (state_q == STROBE),
        .en_i      (state_q == WAIT),
        .expired_o (ctr_expired)
    );

    // Next state and next registered outputs; ack beats a coincident timeout
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        rsp_d       = rsp_q;
        rsp_valid_d = rsp_valid_q;
        wen_d       = 1'b0;
        ren_d       = 1'b0;
        case (state_q)
            IDLE: if (cmd_valid_i) begin
                cmd_d   = '{write: cmd_write_i, addr: cmd_addr_i, wdata: cmd_wdata_i};
                wen_d   = cmd_write_i;
                ren_d   = ~cmd_write_i;
                state_d = STROBE;
            end
            STROBE: state_d = WAIT;
            WAIT: if (ack_i || ctr_expired) begin
                rsp_d       = '{rdata: (ack_i && !cmd_q.write) ? rdata_i : '0, err: ~ack_i};
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: if (rsp_ready_i) begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = state_d == IDLE;
    end

    // State and output registers; reset drops any in-flight transaction
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            rsp_q       <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            wen_q       <= 1'b0;
            ren_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            rsp_q       <= rsp_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            wen_q       <= wen_d;
            ren_q       <= ren_d;
        end
    end

    assign cmd_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_q.rdata;
    assign rsp_err_o   = rsp_q.err;
    assign addr_o      = cmd_q.addr;
    assign wdata_o     = cmd_q.wdata;
    assign wen_o       = wen_q;
    assign ren_o       = ren_q;

endmodule
